// File: rtl/apb_uart_fifo.sv
// APB-attached 16550-subset UART: TX/RX FIFOs, 8N1 serialiser/deserialiser,
// programmable baud divisor, internal loopback and a registered level interrupt.
module apb_uart_fifo #(
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        INT,
    output logic        SOUT,
    input  logic        SIN
);

    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned CW  = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] OS_HALF = CW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // Programmer-visible registers
    logic [3:0]  ier;
    logic [7:0]  lcr, scr, dll, dlm;
    logic [4:0]  mcr;
    logic        fifo_en, oe, fe, int_q;

    // Bus decode
    logic        acc, wr, rd, dlab;
    logic [2:0]  idx;
    logic        thr_wr, rbr_rd, lsr_rd, fcr_wr, div_wr, tx_clr, rx_clr;

    // Baud generator
    logic [15:0] divisor, baud_cnt;
    logic        tick;

    // TX FIFO and serialiser
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [TAW:0]   tx_count;
    logic           tx_empty, tx_full, tx_push, tx_pop, tx_avail;
    logic [7:0]     tx_head;
    state_t         tx_state, tx_state_n;
    logic [CW-1:0]  tx_cnt, tx_cnt_n;
    logic [2:0]     tx_bit, tx_bit_n;
    logic [7:0]     tx_shift, tx_shift_n;
    logic           tx_sout, tx_sout_n;

    // RX FIFO and deserialiser
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [RAW:0]   rx_count;
    logic           rx_empty, rx_full, rx_push, rx_pop, rx_overrun;
    logic           sin_s1, sin_s2, rx_in;
    state_t         rx_state, rx_state_n;
    logic [CW-1:0]  rx_cnt, rx_cnt_n;
    logic [2:0]     rx_bit, rx_bit_n;
    logic [7:0]     rx_shift, rx_shift_n;
    logic           rx_done, rx_stop_bad;

    logic [7:0]  lsr, iir;
    logic [3:0]  iir_id;
    logic        unused_bits;

    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:8]};

    assign acc     = PSEL & PENABLE;
    assign wr      = acc & PWRITE;
    assign rd      = acc & ~PWRITE;
    assign idx     = PADDR[4:2];
    assign dlab    = lcr[7];
    assign thr_wr  = wr && idx == 3'd0 && !dlab;
    assign rbr_rd  = rd && idx == 3'd0 && !dlab;
    assign lsr_rd  = rd && idx == 3'd5;
    assign fcr_wr  = wr && idx == 3'd2;
    assign div_wr  = wr && dlab && (idx == 3'd0 || idx == 3'd1);
    // Toggling the FIFO-enable bit flushes both FIFOs as well as the explicit clear bits
    assign tx_clr  = fcr_wr && (PWDATA[2] || PWDATA[0] != fifo_en);
    assign rx_clr  = fcr_wr && (PWDATA[1] || PWDATA[0] != fifo_en);

    // Register file writes and sticky line-status error flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ier     <= '0;
            lcr     <= '0;
            mcr     <= '0;
            scr     <= '0;
            dll     <= '0;
            dlm     <= '0;
            fifo_en <= 1'b0;
            oe      <= 1'b0;
            fe      <= 1'b0;
        end else begin
            if (wr) begin
                case (idx)
                    3'd0: if (dlab) dll <= PWDATA[7:0];
                    3'd1: if (dlab) dlm <= PWDATA[7:0]; else ier <= PWDATA[3:0];
                    3'd2: fifo_en <= PWDATA[0];
                    3'd3: lcr <= PWDATA[7:0];
                    3'd4: mcr <= PWDATA[4:0];
                    3'd7: scr <= PWDATA[7:0];
                    default: ;
                endcase
            end
            if (lsr_rd) begin
                oe <= 1'b0;
                fe <= 1'b0;
            end
            if (rx_overrun) oe <= 1'b1;
            if (rx_done && rx_stop_bad) fe <= 1'b1;
        end
    end

    assign divisor = {dlm, dll};
    assign tick    = (divisor != 16'd0) && (baud_cnt == divisor - 16'd1);

    // Baud counter: one tick every divisor clocks, restarted on divisor writes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                 baud_cnt <= '0;
        else if (div_wr || divisor == 16'd0 || tick) baud_cnt <= '0;
        else                                     baud_cnt <= baud_cnt + 16'd1;
    end

    assign tx_empty = tx_count == '0;
    assign tx_full  = fifo_en ? (tx_count == (TAW+1)'(TX_DEPTH)) : !tx_empty;
    assign tx_avail = !tx_empty && !tx_clr;
    assign tx_head  = tx_mem[tx_rp];
    assign tx_push  = thr_wr && !tx_clr && (!tx_full || tx_pop);

    // TX FIFO pointers and occupancy; a clear overrides any push or pop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || tx_clr) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // TX FIFO storage
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp] <= PWDATA[7:0];
    end

    // TX FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_sout  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_sout  <= tx_sout_n;
        end
    end

    // TX FSM next state: advances only on baud ticks, LSB first, back-to-back frames
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_sout_n  = tx_sout;
        tx_pop     = 1'b0;
        if (tick) begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_avail) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_head;
                        tx_sout_n  = 1'b0;
                        tx_cnt_n   = '0;
                        tx_state_n = ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_n   = '0;
                        tx_bit_n   = '0;
                        tx_sout_n  = tx_shift[0];
                        tx_state_n = ST_DATA;
                    end else begin
                        tx_cnt_n = tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_n = '0;
                        if (tx_bit == 3'd7) begin
                            tx_sout_n  = 1'b1;
                            tx_state_n = ST_STOP;
                        end else begin
                            tx_bit_n   = tx_bit + 1'b1;
                            tx_shift_n = {1'b0, tx_shift[7:1]};
                            tx_sout_n  = tx_shift[1];
                        end
                    end else begin
                        tx_cnt_n = tx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_n = '0;
                        if (tx_avail) begin
                            tx_pop     = 1'b1;
                            tx_shift_n = tx_head;
                            tx_sout_n  = 1'b0;
                            tx_state_n = ST_START;
                        end else begin
                            tx_state_n = ST_IDLE;
                        end
                    end else begin
                        tx_cnt_n = tx_cnt + 1'b1;
                    end
                end
                default: tx_state_n = ST_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sin_s1 <= 1'b1;
            sin_s2 <= 1'b1;
        end else begin
            sin_s1 <= SIN;
            sin_s2 <= sin_s1;
        end
    end

    assign rx_in = mcr[4] ? tx_sout : sin_s2;

    // RX FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX FSM next state: start validated at half-bit, then mid-bit sampling
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_done     = 1'b0;
        rx_stop_bad = 1'b0;
        if (tick) begin
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_in) begin
                        rx_cnt_n   = '0;
                        rx_state_n = ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == OS_HALF) begin
                        rx_cnt_n   = '0;
                        rx_bit_n   = '0;
                        rx_state_n = rx_in ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_n = rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == OS_LAST) begin
                        rx_cnt_n   = '0;
                        rx_shift_n = {rx_in, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state_n = ST_STOP;
                        else                rx_bit_n   = rx_bit + 1'b1;
                    end else begin
                        rx_cnt_n = rx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == OS_LAST) begin
                        rx_cnt_n    = '0;
                        rx_done     = 1'b1;
                        rx_stop_bad = !rx_in;
                        rx_state_n  = ST_IDLE;
                    end else begin
                        rx_cnt_n = rx_cnt + 1'b1;
                    end
                end
                default: rx_state_n = ST_IDLE;
            endcase
        end
    end

    assign rx_empty   = rx_count == '0;
    assign rx_full    = fifo_en ? (rx_count == (RAW+1)'(RX_DEPTH)) : !rx_empty;
    assign rx_pop     = rbr_rd && !rx_empty && !rx_clr;
    assign rx_push    = rx_done && !rx_clr && (!rx_full || rx_pop);
    assign rx_overrun = rx_done && !rx_clr && rx_full && !rx_pop;

    // RX FIFO pointers and occupancy; a clear overrides any push or pop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || rx_clr) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wp] <= rx_shift;
    end

    assign lsr = {1'b0, tx_empty && tx_state == ST_IDLE, tx_empty, 1'b0, fe, 1'b0, oe, !rx_empty};

    // Interrupt identification, highest priority first
    always_comb begin
        if ((oe || fe) && ier[2])       iir_id = 4'h6;
        else if (!rx_empty && ier[0])   iir_id = 4'h4;
        else if (tx_empty && ier[1])    iir_id = 4'h2;
        else                            iir_id = 4'h1;
    end

    assign iir = {fifo_en, fifo_en, 2'b00, iir_id};

    // Registered level interrupt
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) int_q <= 1'b0;
        else     int_q <= !iir_id[0];
    end

    // Combinational read mux, zero outside a read access
    always_comb begin
        PRDATA = '0;
        if (rd) begin
            case (idx)
                3'd0:    PRDATA[7:0] = dlab ? dll : (rx_empty ? 8'h00 : rx_mem[rx_rp]);
                3'd1:    PRDATA[7:0] = dlab ? dlm : {4'h0, ier};
                3'd2:    PRDATA[7:0] = iir;
                3'd3:    PRDATA[7:0] = lcr;
                3'd4:    PRDATA[7:0] = {3'b000, mcr};
                3'd5:    PRDATA[7:0] = lsr;
                3'd7:    PRDATA[7:0] = scr;
                default: PRDATA[7:0] = 8'h00;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign INT     = int_q;
    assign SOUT    = mcr[4] | tx_sout;

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed-plus-random bench for apb_uart_fifo with a queue-based reference model.
module tb_apb_uart_fifo;

    logic        CLK, RST, PSEL, PENABLE, PWRITE, SIN;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR, INT, SOUT;

    int checks   = 0;
    int failures = 0;
    int unsigned bp = 32;   // CLKs per serial bit: divisor 2 x 16 ticks

    logic [7:0] got_q[$];
    logic       got_stop[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    apb_uart_fifo #(.TX_DEPTH(16), .RX_DEPTH(16), .OVERSAMPLE(16)) dut (
        .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .INT(INT), .SOUT(SOUT), .SIN(SIN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lsr_val(input bit dr, input bit oe, input bit fe, input bit thre, input bit temt);
        return {1'b0, temt, thre, 1'b0, fe, 1'b0, oe, dr};
    endfunction

    function automatic logic [7:0] iir_val(input bit fen, input logic [3:0] ie, input bit err, input bit dr, input bit thre);
        logic [3:0] id;
        if (err && ie[2])       id = 4'h6;
        else if (dr && ie[0])   id = 4'h4;
        else if (thre && ie[1]) id = 4'h2;
        else                    id = 4'h1;
        return {fen, fen, 2'b00, id};
    endfunction

    task automatic apb_wr(input logic [2:0] r, input logic [7:0] d);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = $urandom(); PADDR[4:2] = r;
        PWDATA = $urandom(); PWDATA[7:0] = d;
        @(negedge CLK);
        PENABLE = 1'b1;
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [2:0] r, output logic [31:0] d);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = $urandom(); PADDR[4:2] = r;
        @(negedge CLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] r, input logic [7:0] exp);
        logic [31:0] d;
        apb_rd(r, d);
        check(tag, d, {24'h0, exp});
    endtask

    task automatic wait_got(input string tag, input int n, input int unsigned limit);
        int unsigned c = 0;
        while (got_q.size() < n && c < limit) begin
            @(negedge CLK);
            c++;
        end
        check(tag, got_q.size(), n);
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_count"}, got_q.size(), exp_tx.size());
        while (got_q.size() > 0 && exp_tx.size() > 0) begin
            check({tag, "_stop"}, got_stop.pop_front(), 1'b1);
            check({tag, "_byte"}, got_q.pop_front(), exp_tx.pop_front());
        end
        got_q.delete(); got_stop.delete(); exp_tx.delete();
    endtask

    task automatic drive_sin(input logic [7:0] b, input bit good_stop);
        @(negedge CLK);
        SIN = 1'b0;
        repeat (bp) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            SIN = b[i];
            repeat (bp) @(negedge CLK);
        end
        if (good_stop) begin
            SIN = 1'b1;
            repeat (bp) @(negedge CLK);
        end else begin
            SIN = 1'b0;
            repeat (bp / 2 + 8) @(negedge CLK);
            SIN = 1'b1;
            repeat (bp / 2 - 8) @(negedge CLK);
        end
        repeat (bp) @(negedge CLK);
    endtask

    // Serial line monitor: decodes 8N1 frames on SOUT at mid-bit
    initial begin : monitor
        logic [7:0] d;
        forever begin
            @(negedge CLK);
            if (RST === 1'b0 && SOUT === 1'b0) begin
                repeat (bp / 2) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (bp) @(negedge CLK);
                    d[i] = SOUT;
                end
                repeat (bp) @(negedge CLK);
                got_stop.push_back(SOUT);
                got_q.push_back(d);
            end
        end
    end

    initial begin : stim
        logic [7:0]  b, b0, b1, b2, r;
        logic [31:0] d;
        int unsigned c;

        RST = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; SIN = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_sout", SOUT, 1'b1);
        check("reset_int", INT, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // 1. reset state and register access
        check("prdata_idle", PRDATA, 32'h0);
        check("pready", PREADY, 1'b1);
        check("pslverr", PSLVERR, 1'b0);
        chk_rd("reset_lsr", 3'd5, lsr_val(0, 0, 0, 1, 1));
        chk_rd("reset_iir", 3'd2, iir_val(0, 4'h0, 0, 0, 1));
        check("reset_int_after", INT, 1'b0);
        check("reset_sout_after", SOUT, 1'b1);
        b = 8'($urandom());
        apb_wr(3'd7, b);
        chk_rd("scr_rw", 3'd7, b);
        chk_rd("msr_zero", 3'd6, 8'h00);
        apb_wr(3'd5, 8'hFF);
        chk_rd("lsr_write_ignored", 3'd5, lsr_val(0, 0, 0, 1, 1));
        apb_wr(3'd4, 8'hEF);
        chk_rd("mcr_mask", 3'd4, 8'h0F);
        apb_wr(3'd4, 8'h00);
        apb_wr(3'd1, 8'hFF);
        chk_rd("ier_mask", 3'd1, 8'h0F);
        chk_rd("iir_thre", 3'd2, iir_val(0, 4'hF, 0, 0, 1));
        check("int_thre", INT, 1'b1);
        apb_wr(3'd1, 8'h00);
        @(negedge CLK);
        check("int_thre_off", INT, 1'b0);
        apb_wr(3'd3, 8'h80);
        chk_rd("lcr_dlab", 3'd3, 8'h80);
        b0 = 8'($urandom()); b1 = 8'($urandom());
        apb_wr(3'd0, b0);
        apb_wr(3'd1, b1);
        chk_rd("dll_rw", 3'd0, b0);
        chk_rd("dlm_rw", 3'd1, b1);

        // 2. divisor 2, 0x55 on SOUT with 32-CLK bits
        apb_wr(3'd0, 8'd2);
        apb_wr(3'd1, 8'd0);
        apb_wr(3'd3, 8'h03);
        apb_wr(3'd0, 8'h55);
        exp_tx.push_back(8'h55);
        c = 0;
        while (SOUT !== 1'b0 && c < 200) begin @(negedge CLK); c++; end
        check("start_seen", SOUT, 1'b0);
        c = 0;
        while (SOUT === 1'b0 && c < 1000) begin @(negedge CLK); c++; end
        check("start_bit_len", c, 32);
        chk_rd("lsr_busy", 3'd5, lsr_val(0, 0, 0, 1, 0));
        wait_got("frame55_done", 1, 2000);
        repeat (bp / 2 + 4) @(negedge CLK);
        chk_rd("lsr_temt", 3'd5, lsr_val(0, 0, 0, 1, 1));
        compare_tx("tx55");

        // random back-to-back frames through the enabled FIFO
        apb_wr(3'd2, 8'h01);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom());
            exp_tx.push_back(b);
            apb_wr(3'd0, b);
        end
        wait_got("burst_done", 3, 5000);
        compare_tx("tx_burst");
        repeat (bp) @(negedge CLK);

        // 3. loopback receive with DR interrupt
        apb_wr(3'd4, 8'h10);
        apb_wr(3'd1, 8'h01);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom());
            exp_rx.push_back(b);
            apb_wr(3'd0, b);
        end
        check("int_before_rx", INT, 1'b0);
        c = 0;
        while (INT !== 1'b1 && c < 2000) begin @(negedge CLK); c++; end
        check("int_rise", INT, 1'b1);
        check("loopback_sout", SOUT, 1'b1);
        chk_rd("iir_dr", 3'd2, iir_val(1, 4'h1, 0, 1, 0));
        repeat (40 * bp) @(negedge CLK);
        while (exp_rx.size() > 0) chk_rd("loop_rbr", 3'd0, exp_rx.pop_front());
        chk_rd("loop_lsr_empty", 3'd5, lsr_val(0, 0, 0, 1, 1));
        repeat (2) @(negedge CLK);
        check("loop_int_fall", INT, 1'b0);
        check("loop_no_sout_frames", got_q.size(), 0);

        // 4. RX overrun: 17 bytes into a 16-deep RX FIFO
        apb_wr(3'd1, 8'h05);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom());
            if (i < 16) exp_rx.push_back(b);
            apb_wr(3'd0, b);
            if (i == 0) repeat (10) @(negedge CLK);
        end
        repeat (17 * 10 * bp + 8 * bp) @(negedge CLK);
        chk_rd("ovr_iir", 3'd2, iir_val(1, 4'h5, 1, 1, 1));
        check("ovr_int", INT, 1'b1);
        chk_rd("ovr_lsr", 3'd5, lsr_val(1, 1, 0, 1, 1));
        chk_rd("ovr_lsr_cleared", 3'd5, lsr_val(1, 0, 0, 1, 1));
        while (exp_rx.size() > 0) chk_rd("ovr_rbr", 3'd0, exp_rx.pop_front());
        chk_rd("ovr_lsr_empty", 3'd5, lsr_val(0, 0, 0, 1, 1));
        chk_rd("rbr_empty_zero", 3'd0, 8'h00);
        chk_rd("iir_none", 3'd2, iir_val(1, 4'h5, 0, 0, 1));

        // 5. SIN glitch, good frame, frame with bad stop bit
        apb_wr(3'd4, 8'h00);
        @(negedge CLK); SIN = 1'b0;
        repeat (8) @(negedge CLK); SIN = 1'b1;
        repeat (12 * bp) @(negedge CLK);
        chk_rd("glitch_no_byte", 3'd5, lsr_val(0, 0, 0, 1, 1));
        b = 8'($urandom());
        drive_sin(b, 1'b1);
        chk_rd("sin_good_lsr", 3'd5, lsr_val(1, 0, 0, 1, 1));
        chk_rd("sin_good_rbr", 3'd0, b);
        b = 8'($urandom());
        drive_sin(b, 1'b0);
        chk_rd("fe_iir", 3'd2, iir_val(1, 4'h5, 1, 1, 1));
        chk_rd("fe_lsr", 3'd5, lsr_val(1, 0, 1, 1, 1));
        chk_rd("fe_rbr", 3'd0, b);
        chk_rd("fe_cleared", 3'd5, lsr_val(0, 0, 0, 1, 1));

        // 6a. FIFOs disabled while TX busy: second queued write dropped
        b0 = 8'($urandom()); b1 = 8'($urandom()); b2 = 8'($urandom());
        apb_wr(3'd0, b0);
        repeat (2 * bp) @(negedge CLK);
        apb_wr(3'd2, 8'h00);
        apb_wr(3'd0, b1);
        apb_wr(3'd0, b2);
        exp_tx.push_back(b0);
        exp_tx.push_back(b1);
        chk_rd("depth1_lsr_full", 3'd5, lsr_val(0, 0, 0, 0, 0));
        chk_rd("depth1_iir", 3'd2, iir_val(0, 4'h5, 0, 0, 0));
        wait_got("depth1_frames", 2, 5000);
        repeat (bp / 2 + 4) @(negedge CLK);
        chk_rd("depth1_lsr_idle", 3'd5, lsr_val(0, 0, 0, 1, 1));
        repeat (12 * bp) @(negedge CLK);
        compare_tx("depth1");

        // 6b. FCR clear mid-frame empties both FIFOs, current frame completes
        apb_wr(3'd2, 8'h01);
        r = 8'($urandom());
        drive_sin(r, 1'b1);
        chk_rd("clr_rx_loaded", 3'd5, lsr_val(1, 0, 0, 1, 1));
        b0 = 8'($urandom()); b1 = 8'($urandom()); b2 = 8'($urandom());
        apb_wr(3'd0, b0);
        repeat (2 * bp) @(negedge CLK);
        apb_wr(3'd0, b1);
        apb_wr(3'd0, b2);
        chk_rd("clr_before", 3'd5, lsr_val(1, 0, 0, 0, 0));
        apb_wr(3'd2, 8'h07);
        chk_rd("clr_after", 3'd5, lsr_val(0, 0, 0, 1, 0));
        chk_rd("clr_iir", 3'd2, iir_val(1, 4'h5, 0, 0, 1));
        exp_tx.push_back(b0);
        wait_got("clr_frame_done", 1, 3000);
        repeat (12 * bp) @(negedge CLK);
        chk_rd("clr_lsr_idle", 3'd5, lsr_val(0, 0, 0, 1, 1));
        compare_tx("clr");

        // 7. asynchronous reset mid-frame, then divisor 0 freezes TX
        apb_wr(3'd0, 8'($urandom()));
        c = 0;
        while (SOUT !== 1'b0 && c < 200) begin @(negedge CLK); c++; end
        check("rst_frame_started", SOUT, 1'b0);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1 check("rst_async_sout", SOUT, 1'b1);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk_rd("rst2_lsr", 3'd5, lsr_val(0, 0, 0, 1, 1));
        chk_rd("rst2_lcr", 3'd3, 8'h00);
        chk_rd("rst2_iir", 3'd2, iir_val(0, 4'h0, 0, 0, 1));
        apb_wr(3'd0, 8'h00);
        repeat (100) @(negedge CLK);
        check("div0_sout_idle", SOUT, 1'b1);
        chk_rd("div0_frozen_lsr", 3'd5, lsr_val(0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
